// File: rtl/apb_chargen_pkg.sv
// Shared types and helpers for the APB text-mode memory bridge.
// Region/state encodings plus the glyph-row byte merge.
package apb_chargen_pkg;

  localparam int MAP_DEPTH = 2400;
  localparam int TBL_DEPTH = 128;
  localparam int GLYPH_W   = 128;

  typedef enum logic [1:0] {
    RG_CH,
    RG_COL,
    RG_TBL,
    RG_ERR
  } region_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_MAP_WR,
    ST_MAP_RD,
    ST_TBL_RD,
    ST_TBL_RMW,
    ST_ERR,
    ST_DONE
  } state_e;

  function automatic logic [GLYPH_W-1:0] strb_merge(
    input logic [GLYPH_W-1:0] row,
    input logic [1:0]         slice,
    input logic [31:0]        wdata,
    input logic [3:0]         strb
  );
    logic [GLYPH_W-1:0] r;
    r = row;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) r[32*slice + 8*i +: 8] = wdata[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/apb_chargen_mem_bridge.sv
// APB4 slave onto port A of the char map, colour map and RW glyph table.
// Map words go out one byte lane per cycle; glyph writes are read-modify-write.
module apb_chargen_mem_bridge
  import apb_chargen_pkg::*;
#(
  parameter int APB_ADDR_W = 14,
  parameter int MAP_DEPTH  = apb_chargen_pkg::MAP_DEPTH,
  parameter int TBL_DEPTH  = apb_chargen_pkg::TBL_DEPTH,
  parameter int GLYPH_W    = apb_chargen_pkg::GLYPH_W,
  localparam int MAP_AW    = $clog2(MAP_DEPTH),
  localparam int TBL_AW    = $clog2(TBL_DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  arstn_i,
  input  logic                  psel_i,
  input  logic                  penable_i,
  input  logic                  pwrite_i,
  input  logic [APB_ADDR_W-1:0] paddr_i,
  input  logic [31:0]           pwdata_i,
  input  logic [3:0]            pstrb_i,
  output logic [31:0]           prdata_o,
  output logic                  pready_o,
  output logic                  pslverr_o,
  output logic [MAP_AW-1:0]     ch_map_addr_o,
  output logic [7:0]            ch_map_wdata_o,
  output logic                  ch_map_wen_o,
  input  logic [7:0]            ch_map_rdata_i,
  output logic [MAP_AW-1:0]     col_map_addr_o,
  output logic [7:0]            col_map_wdata_o,
  output logic                  col_map_wen_o,
  input  logic [7:0]            col_map_rdata_i,
  output logic [TBL_AW-1:0]     ch_t_rw_addr_o,
  output logic [GLYPH_W-1:0]    ch_t_rw_wdata_o,
  output logic                  ch_t_rw_wen_o,
  input  logic [GLYPH_W-1:0]    ch_t_rw_rdata_i
);

  localparam int OFF_W = 12;

  state_e               state_q;
  logic [1:0]           lane_q;
  region_e              region_q;
  logic [OFF_W-1:0]     off_q;
  logic [TBL_AW-1:0]    idx_q;
  logic [1:0]           slice_q;
  logic [31:0]          wdata_q;
  logic [3:0]           strb_q;
  logic [31:0]          acc_q;
  logic [GLYPH_W-1:0]   row_q;

  region_e              rg_in;
  logic [OFF_W-1:0]     off_in;
  logic                 bad_in;
  logic                 start;
  logic                 unused_paddr;

  assign unused_paddr = ^paddr_i[1:0];
  assign rg_in  = region_e'(paddr_i[13:12]);
  assign off_in = {paddr_i[11:2], 2'b00};
  assign start  = (state_q == ST_IDLE) & psel_i & penable_i & arstn_i;

  always_comb begin
    bad_in = 1'b1;
    unique case (rg_in)
      RG_CH, RG_COL: bad_in = 32'(off_in) >= MAP_DEPTH;
      RG_TBL:        bad_in = paddr_i[11];
      default:       bad_in = 1'b1;
    endcase
  end

  // In IDLE the first lane is served straight from the bus so the op starts at T
  region_e          rg_c;
  logic [OFF_W-1:0] off_c;
  logic [31:0]      wd_c;
  logic [3:0]       st_c;
  logic [1:0]       lane_c;
  logic [TBL_AW-1:0] idx_c;

  always_comb begin
    rg_c   = region_q;
    off_c  = off_q;
    wd_c   = wdata_q;
    st_c   = strb_q;
    lane_c = lane_q;
    idx_c  = idx_q;
    if (state_q == ST_IDLE) begin
      rg_c   = rg_in;
      off_c  = off_in;
      wd_c   = pwdata_i;
      st_c   = pstrb_i;
      lane_c = 2'd0;
      idx_c  = paddr_i[10:4];
    end
  end

  logic              map_on;
  logic              map_wr;
  logic [MAP_AW-1:0] m_addr;
  logic [7:0]        m_wdata;
  logic              m_wen;
  logic              tbl_on;
  logic [7:0]        map_rdata;

  assign map_on = (start & ~bad_in & (rg_in == RG_CH || rg_in == RG_COL))
                | (state_q == ST_MAP_WR)
                | (state_q == ST_MAP_RD && lane_q != 2'd0);
  assign map_wr = start ? pwrite_i : (state_q == ST_MAP_WR);
  assign m_addr = map_on ? MAP_AW'(off_c + OFF_W'(lane_c)) : '0;
  assign m_wdata = (map_on & map_wr) ? wd_c[8*lane_c +: 8] : 8'd0;
  assign m_wen   = map_on & map_wr & st_c[lane_c];

  assign ch_map_addr_o   = (rg_c == RG_CH) ? m_addr : '0;
  assign ch_map_wdata_o  = (rg_c == RG_CH) ? m_wdata : 8'd0;
  assign ch_map_wen_o    = (rg_c == RG_CH) & m_wen;
  assign col_map_addr_o  = (rg_c == RG_COL) ? m_addr : '0;
  assign col_map_wdata_o = (rg_c == RG_COL) ? m_wdata : 8'd0;
  assign col_map_wen_o   = (rg_c == RG_COL) & m_wen;

  assign tbl_on = (start & ~bad_in & (rg_in == RG_TBL))
                | (state_q == ST_TBL_RD)
                | (state_q == ST_TBL_RMW);
  assign ch_t_rw_addr_o  = tbl_on ? idx_c : '0;
  assign ch_t_rw_wen_o   = (state_q == ST_TBL_RMW) & (lane_q == 2'd1);
  assign ch_t_rw_wdata_o = ch_t_rw_wen_o ? row_q : '0;

  assign map_rdata = (region_q == RG_CH) ? ch_map_rdata_i : col_map_rdata_i;

  assign pready_o  = (state_q == ST_DONE) | (start & bad_in);
  assign pslverr_o = start & bad_in;
  assign prdata_o  = (state_q == ST_DONE) ? acc_q : 32'd0;

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      state_q  <= ST_IDLE;
      lane_q   <= 2'd0;
      region_q <= RG_CH;
      off_q    <= '0;
      idx_q    <= '0;
      slice_q  <= 2'd0;
      wdata_q  <= 32'd0;
      strb_q   <= 4'd0;
      acc_q    <= 32'd0;
      row_q    <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            region_q <= rg_in;
            off_q    <= off_in;
            idx_q    <= paddr_i[10:4];
            slice_q  <= paddr_i[3:2];
            wdata_q  <= pwdata_i;
            strb_q   <= pstrb_i;
            acc_q    <= 32'd0;
            if (bad_in) begin
              state_q <= ST_ERR;
            end else if (rg_in == RG_TBL) begin
              lane_q  <= 2'd0;
              state_q <= pwrite_i ? ST_TBL_RMW : ST_TBL_RD;
            end else begin
              lane_q  <= 2'd1;
              state_q <= pwrite_i ? ST_MAP_WR : ST_MAP_RD;
            end
          end
        end
        ST_MAP_WR: begin
          lane_q <= lane_q + 2'd1;
          if (lane_q == 2'd3) state_q <= ST_DONE;
        end
        ST_MAP_RD: begin
          // Each cycle captures the byte addressed one cycle earlier
          acc_q[8*(lane_q - 2'd1) +: 8] <= map_rdata;
          if (lane_q == 2'd0) state_q <= ST_DONE;
          else                lane_q  <= lane_q + 2'd1;
        end
        ST_TBL_RD: begin
          acc_q   <= ch_t_rw_rdata_i[32*slice_q +: 32];
          state_q <= ST_DONE;
        end
        ST_TBL_RMW: begin
          if (lane_q == 2'd0) begin
            row_q  <= strb_merge(ch_t_rw_rdata_i, slice_q,
                                 wdata_q, strb_q);
            lane_q <= 2'd1;
          end else begin
            lane_q  <= 2'd0;
            state_q <= ST_DONE;
          end
        end
        ST_ERR:  state_q <= ST_IDLE;
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_chargen_mem_bridge.sv
// Directed bench for apb_chargen_mem_bridge with behavioural BRAM port A.
// Expected values are hand-computed constants.
module tb_apb_chargen_mem_bridge;

  logic         clk_i = 1'b0;
  logic         arstn_i;
  logic         psel_i, penable_i, pwrite_i;
  logic [13:0]  paddr_i;
  logic [31:0]  pwdata_i;
  logic [3:0]   pstrb_i;
  logic [31:0]  prdata_o;
  logic         pready_o, pslverr_o;
  logic [11:0]  ch_map_addr_o, col_map_addr_o;
  logic [7:0]   ch_map_wdata_o, col_map_wdata_o;
  logic         ch_map_wen_o, col_map_wen_o;
  logic [7:0]   ch_map_rdata_i, col_map_rdata_i;
  logic [6:0]   ch_t_rw_addr_o;
  logic [127:0] ch_t_rw_wdata_o;
  logic         ch_t_rw_wen_o;
  logic [127:0] ch_t_rw_rdata_i;

  always #5 clk_i = ~clk_i;

  apb_chargen_mem_bridge dut (
    .clk_i(clk_i), .arstn_i(arstn_i),
    .psel_i(psel_i), .penable_i(penable_i),
    .pwrite_i(pwrite_i), .paddr_i(paddr_i),
    .pwdata_i(pwdata_i), .pstrb_i(pstrb_i),
    .prdata_o(prdata_o), .pready_o(pready_o),
    .pslverr_o(pslverr_o),
    .ch_map_addr_o(ch_map_addr_o),
    .ch_map_wdata_o(ch_map_wdata_o),
    .ch_map_wen_o(ch_map_wen_o),
    .ch_map_rdata_i(ch_map_rdata_i),
    .col_map_addr_o(col_map_addr_o),
    .col_map_wdata_o(col_map_wdata_o),
    .col_map_wen_o(col_map_wen_o),
    .col_map_rdata_i(col_map_rdata_i),
    .ch_t_rw_addr_o(ch_t_rw_addr_o),
    .ch_t_rw_wdata_o(ch_t_rw_wdata_o),
    .ch_t_rw_wen_o(ch_t_rw_wen_o),
    .ch_t_rw_rdata_i(ch_t_rw_rdata_i)
  );

  logic [7:0]   chm [4096];
  logic [7:0]   colm[4096];
  logic [127:0] gm  [128];
  int           ch_wcyc[4096];
  int           cyc = 0;
  int           t0 = 0;
  int           wen_cnt = 0;
  int           n_chk = 0;
  int           n_pass = 0;

  always @(posedge clk_i) begin
    cyc <= cyc + 1;
    if (ch_map_wen_o) chm[ch_map_addr_o] <= ch_map_wdata_o;
    ch_map_rdata_i <= chm[ch_map_addr_o];
    if (col_map_wen_o) colm[col_map_addr_o] <= col_map_wdata_o;
    col_map_rdata_i <= colm[col_map_addr_o];
    if (ch_t_rw_wen_o) gm[ch_t_rw_addr_o] <= ch_t_rw_wdata_o;
    ch_t_rw_rdata_i <= gm[ch_t_rw_addr_o];
  end

  always @(negedge clk_i) begin
    if (ch_map_wen_o) ch_wcyc[ch_map_addr_o] = cyc - t0;
    if (ch_map_wen_o | col_map_wen_o | ch_t_rw_wen_o)
      wen_cnt = wen_cnt + 1;
  end

  task automatic check(input string tag,
                       input logic [127:0] got,
                       input logic [127:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic apb(input logic wr, input logic [13:0] a,
                     input logic [31:0] d, input logic [3:0] s,
                     output logic [31:0] rd, output logic er,
                     output int w);
    @(posedge clk_i); #1;
    psel_i = 1'b1; penable_i = 1'b0; pwrite_i = wr;
    paddr_i = a; pwdata_i = d; pstrb_i = s;
    @(posedge clk_i); #1;
    penable_i = 1'b1;
    t0 = cyc;
    w = 0;
    @(negedge clk_i);
    while (!pready_o && w < 20) begin
      @(posedge clk_i); #1;
      w++;
      @(negedge clk_i);
    end
    rd = prdata_o;
    er = pslverr_o;
    if (!pready_o) begin
      check("timeout", 1'b0, 1'b1);
      w = 99;
    end
    @(posedge clk_i); #1;
    psel_i = 1'b0; penable_i = 1'b0;
  endtask

  logic [31:0] rd;
  logic        er;
  int          w;
  int          wc;

  initial begin
    arstn_i = 1'b0;
    psel_i = 0; penable_i = 0; pwrite_i = 0;
    paddr_i = '0; pwdata_i = '0; pstrb_i = '0;
    for (int i = 0; i < 4096; i++) ch_wcyc[i] = -1;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_prdata", prdata_o, 0);
    check("rst_pready", pready_o, 0);
    check("rst_pslverr", pslverr_o, 0);
    check("rst_wen", {ch_map_wen_o, col_map_wen_o, ch_t_rw_wen_o}, 0);
    @(posedge clk_i); #1 arstn_i = 1'b1;

    // char map word write, all lanes
    apb(1, 14'h0000, 32'h44434241, 4'hF, rd, er, w);
    check("wr_wait", w, 4);
    check("wr_err", er, 0);
    check("ch0", chm[0], 8'h41);
    check("ch1", chm[1], 8'h42);
    check("ch2", chm[2], 8'h43);
    check("ch3", chm[3], 8'h44);
    for (int i = 0; i < 4; i++) check("lane_t", ch_wcyc[i], i);

    // colour map strobed write
    apb(1, 14'h1004, 32'h77665544, 4'hF, rd, er, w);
    apb(1, 14'h1004, 32'hAABBCCDD, 4'b0101, rd, er, w);
    check("col_wait", w, 4);
    check("col4", colm[4], 8'hDD);
    check("col5", colm[5], 8'h55);
    check("col6", colm[6], 8'hBB);
    check("col7", colm[7], 8'h77);

    // char map read back
    apb(0, 14'h0000, 32'h0, 4'h0, rd, er, w);
    check("rd_data", rd, 32'h44434241);
    check("rd_wait", w, 5);
    check("rd_err", er, 0);
    apb(0, 14'h1004, 32'h0, 4'h0, rd, er, w);
    check("col_rd", rd, 32'h77BB55DD);

    // glyph 3 to all ones, then clear bits 47:32
    for (int k = 0; k < 4; k++)
      apb(1, 14'h2030 | 14'(4*k), 32'hFFFFFFFF, 4'hF, rd, er, w);
    apb(1, 14'h2034, 32'h0, 4'b0011, rd, er, w);
    check("rmw_wait", w, 3);
    check("row3", gm[3], 128'hFFFFFFFFFFFFFFFFFFFF0000FFFFFFFF);
    apb(1, 14'h2034, 32'h12345678, 4'b0000, rd, er, w);
    check("rmw0_wait", w, 3);
    check("row3_nostrb", gm[3], 128'hFFFFFFFFFFFFFFFFFFFF0000FFFFFFFF);
    apb(0, 14'h2034, 32'h0, 4'h0, rd, er, w);
    check("g_rd1", rd, 32'hFFFF0000);
    check("g_rd_wait", w, 2);
    apb(0, 14'h2030, 32'h0, 4'h0, rd, er, w);
    check("g_rd0", rd, 32'hFFFFFFFF);

    // error responses
    wc = wen_cnt;
    apb(0, 14'h0960, 32'h0, 4'h0, rd, er, w);
    check("e1_wait", w, 0);
    check("e1_err", er, 1);
    check("e1_data", rd, 0);
    apb(1, 14'h3000, 32'hFFFFFFFF, 4'hF, rd, er, w);
    check("e2_wait", w, 0);
    check("e2_err", er, 1);
    check("e2_data", rd, 0);
    apb(1, 14'h2800, 32'hFFFFFFFF, 4'hF, rd, er, w);
    check("e3_err", er, 1);
    check("e_nowen", wen_cnt - wc, 0);

    // reset in the middle of a map write
    apb(1, 14'h0010, 32'h0, 4'hF, rd, er, w);
    @(posedge clk_i); #1;
    psel_i = 1; penable_i = 0; pwrite_i = 1;
    paddr_i = 14'h0010; pwdata_i = 32'h87654321; pstrb_i = 4'hF;
    @(posedge clk_i); #1 penable_i = 1;
    @(posedge clk_i);
    @(posedge clk_i); #1 arstn_i = 1'b0;
    #1;
    check("rst_mid_wen", ch_map_wen_o, 0);
    check("rst_mid_rdy", pready_o, 0);
    psel_i = 0; penable_i = 0;
    @(posedge clk_i); #1 arstn_i = 1'b1;
    check("abort_b0", chm[16], 8'h21);
    check("abort_b1", chm[17], 8'h43);
    check("abort_b2", chm[18], 8'h00);
    check("abort_b3", chm[19], 8'h00);
    apb(0, 14'h0010, 32'h0, 4'h0, rd, er, w);
    check("post_rst_rd", rd, 32'h00004321);
    check("post_rst_wait", w, 5);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
